mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped 32-bit timer/compare peripheral on the LEGv8 data bus, sitting directly downstream of an
//  AddressDetect instance whose out drives sel. Provides prescaled up-counter, compare match flag, interrupt.
//  Software reads/writes five 64-bit-aligned registers; ready completes each access one cycle later.
// PARAMETERS
//  DATA_WIDTH  64   bus data width; registers zero-extended on read
//  CNT_WIDTH   32   width of COUNT, COMPARE, PRESCALE
// PORTS
//  clk         in   1           single clock, all state on rising edge
//  reset       in   1           synchronous, active-high
//  sel         in   1           chip select from address decoder (base match)
//  address     in   6           byte offset within block (address[5:0] of bus)
//  write_en    in   1           write strobe, qualified by sel
//  read_en     in   1           read strobe, qualified by sel
//  write_data  in   DATA_WIDTH  write data; low CNT_WIDTH bits used
//  read_data   out  DATA_WIDTH  registered read data, valid when ready=1
//  ready       out  1           one-cycle pulse, access complete
//  irq         out  1           registered level interrupt
// BEHAVIOUR
//  Register map (index = address[5:3], address[2:0] ignored):
//   0 CTRL[2:0]: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; 1 PRESCALE; 2 COUNT; 3 COMPARE; 4 STATUS bit0 MATCH (W1C)
//   5-7 unmapped: read 0, writes ignored, ready still pulses.
//  Reset: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=all ones, MATCH=0, presc_cnt=0; read_data=0, ready=0, irq=0.
//  Access: accepted in any cycle with sel & (read_en|write_en); ready=1 next cycle; back-to-back accepted every cycle.
//   Write takes effect at the accepting edge. Read: read_data captured at accepting edge (pre-write value), else 0.
//   read_en & write_en together: write performed, read_data returns pre-write value. sel=0: strobes ignored.
//  Prescaler: EN=1 -> presc_cnt counts 0..PRESCALE; tick asserted the cycle presc_cnt==PRESCALE, then wraps to 0.
//   PRESCALE=0 -> tick every cycle. EN=0 -> presc_cnt held at 0, no ticks. Write to CTRL or PRESCALE clears presc_cnt.
//  Counter on tick: if COUNT==COMPARE -> MATCH<=1 and COUNT<=0 when AUTORELOAD else COUNT+1;
//   otherwise COUNT+1, wrapping 2^CNT_WIDTH-1 -> 0 silently.
//  Collisions: SW write to COUNT same cycle as tick -> SW value wins, no increment, no match that cycle.
//   W1C of MATCH same cycle as new match -> set wins (MATCH stays 1).
//  irq <= MATCH & IRQ_EN (one cycle after MATCH set). Clearing IRQ_EN or MATCH drops irq next cycle.
//  reset mid-access: ready not asserted for the aborted access; all state returns to reset values.
// CONFIGURATION
//  MMIO_TIMER_PWM_EN defined: extra port pwm_out (out, 1), registered; pwm_out=1 while COUNT<COMPARE and EN=1, else 0;
//   reset value 0. CTRL bit3 PWM_INV inverts pwm_out (readable/writable).
//  Undefined: no pwm_out port; CTRL bit3 reads 0, write ignored.
// STRUCTURE
//  Shared header legv8_periph_defs.vh: register index constants (TMR_CTRL..TMR_STATUS), CTRL bit positions,
//   default CNT_WIDTH; reused by other MMIO peripherals and the bench.
//  One sub-module: mmio_timer_prescaler (clk, reset, en, clr, prescale -> tick). Register file + counter in top.
// TESTING
//  1 reset then read all 5 regs -> 0,0,0,0xFFFFFFFF,0; each ready exactly 1 cycle after request; irq=0.
//  2 PRESCALE=3, COMPARE=5, CTRL=0x7 -> COUNT increments every 4 cycles; MATCH set on 6th tick, COUNT=0, irq next cycle.
//  3 CTRL=0x1 (no autoreload), COUNT=0xFFFFFFFE, PRESCALE=0, COMPARE=0x10 -> COUNT wraps to 0, MATCH only at 0x10.
//  4 Write COUNT=0x100 same cycle as tick -> COUNT=0x100 next cycle; W1C STATUS coincident with match -> MATCH stays 1.
//  5 Back-to-back: read STATUS, write 1 STATUS, read STATUS, sel=0 write -> reads 1 then 0, sel=0 write no effect, 3 ready pulses.
//  6 Reset asserted mid-count (COUNT=0x20) with pending read -> no ready, all regs at reset values; MMIO_TIMER_PWM_EN
//    build: COMPARE=4, PRESCALE=0 -> pwm_out high for COUNT 0..3 per period.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL bit positions and default widths for the LEGv8 MMIO timer.
// Also used by the bench. MMIO_TIMER_PWM_EN widens CTRL by the PWM_INV bit.
package mmio_timer_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_CNT_WIDTH  = 32;

    // Register index taken from address[5:3]; indices 5-7 are unmapped.
    typedef enum logic [2:0] {
        TMR_CTRL     = 3'd0,
        TMR_PRESCALE = 3'd1,
        TMR_COUNT    = 3'd2,
        TMR_COMPARE  = 3'd3,
        TMR_STATUS   = 3'd4
    } tmr_reg_e;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_PWM_INV    = 3;
    localparam int STATUS_MATCH    = 0;

`ifdef MMIO_TIMER_PWM_EN
    localparam int CTRL_WIDTH = 4;
`else
    localparam int CTRL_WIDTH = 3;
`endif

    // Register index of a bus byte offset; the low three bits select a byte lane and are ignored.
    function automatic tmr_reg_e reg_index(input logic [5:3] addr_hi);
        return tmr_reg_e'(addr_hi);
    endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler for mmio_timer: emits one tick every PRESCALE+1 enabled cycles.
// A clear restarts the period; disabling holds the phase counter at zero.
module mmio_timer_prescaler #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] prescale,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] presc_cnt;
    logic                 at_limit;

    assign at_limit = (presc_cnt == prescale);
    assign tick     = en & at_limit;

    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            presc_cnt <= '0;
        end else if (at_limit) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare match flag and level interrupt.
// Optional MMIO_TIMER_PWM_EN adds a registered pwm_out and CTRL bit3 PWM_INV.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [5:0]            address,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
`ifdef MMIO_TIMER_PWM_EN
    output logic                  pwm_out,
`endif
    output logic                  irq
);

    // Handshake: an access is accepted on any rising edge where sel & (read_en | write_en);
    // ready pulses for exactly the following cycle with read_data; there is no back-pressure,
    // so a new access may be accepted on every edge.
    logic                  access;
    logic                  rd_acc;
    logic                  wr_acc;
    tmr_reg_e              idx;

    logic [CTRL_WIDTH-1:0] ctrl;
    logic [CNT_WIDTH-1:0]  prescale;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  compare;
    logic                  match;

    logic                  wr_ctrl;
    logic                  wr_prescale;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_status;

    logic                  tick;
    logic                  match_set;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic                  unused_bus_bits;
    assign unused_bus_bits = ^{address[2:0], write_data[DATA_WIDTH-1:CNT_WIDTH]};

    assign access = sel & (read_en | write_en);
    assign rd_acc = sel & read_en;
    assign wr_acc = sel & write_en;
    assign idx    = reg_index(address[5:3]);

    always_comb begin
        wr_ctrl     = 1'b0;
        wr_prescale = 1'b0;
        wr_count    = 1'b0;
        wr_compare  = 1'b0;
        wr_status   = 1'b0;
        if (wr_acc) begin
            case (idx)
                TMR_CTRL:     wr_ctrl     = 1'b1;
                TMR_PRESCALE: wr_prescale = 1'b1;
                TMR_COUNT:    wr_count    = 1'b1;
                TMR_COMPARE:  wr_compare  = 1'b1;
                TMR_STATUS:   wr_status   = 1'b1;
                default:      ;
            endcase
        end
    end

    mmio_timer_prescaler #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl[CTRL_EN]),
        .clr      (wr_ctrl | wr_prescale),
        .prescale (prescale),
        .tick     (tick)
    );

    // A software write to COUNT overrides the tick entirely, including any match it would raise.
    always_comb begin
        count_nxt = count;
        match_set = 1'b0;
        if (wr_count) begin
            count_nxt = write_data[CNT_WIDTH-1:0];
        end else if (tick) begin
            if (count == compare) begin
                match_set = 1'b1;
                count_nxt = ctrl[CTRL_AUTORELOAD] ? '0 : count + 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (idx)
            TMR_CTRL:     rd_mux[CTRL_WIDTH-1:0] = ctrl;
            TMR_PRESCALE: rd_mux[CNT_WIDTH-1:0]  = prescale;
            TMR_COUNT:    rd_mux[CNT_WIDTH-1:0]  = count;
            TMR_COMPARE:  rd_mux[CNT_WIDTH-1:0]  = compare;
            TMR_STATUS:   rd_mux[STATUS_MATCH]   = match;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= '0;
            count    <= '0;
            compare  <= '1;
        end else begin
            if (wr_ctrl)     ctrl     <= write_data[CTRL_WIDTH-1:0];
            if (wr_prescale) prescale <= write_data[CNT_WIDTH-1:0];
            if (wr_compare)  compare  <= write_data[CNT_WIDTH-1:0];
            count <= count_nxt;
        end
    end

    // A new match beats a coincident write-one-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            match <= 1'b0;
        end else if (match_set) begin
            match <= 1'b1;
        end else if (wr_status && write_data[STATUS_MATCH]) begin
            match <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready     <= 1'b0;
            read_data <= '0;
            irq       <= 1'b0;
        end else begin
            ready     <= access;
            read_data <= rd_acc ? rd_mux : '0;
            irq       <= match & ctrl[CTRL_IRQ_EN];
        end
    end

`ifdef MMIO_TIMER_PWM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (ctrl[CTRL_EN] & (count < compare)) ^ ctrl[CTRL_PWM_INV];
        end
    end
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// Randomised scoreboard bench for mmio_timer against a cycle-level reference model.
// Honours MMIO_TIMER_PWM_EN to also check pwm_out and CTRL bit3.
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam int DW = 64;
    localparam int CW = 32;
`ifdef MMIO_TIMER_PWM_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic [5:0]    address = '0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          ready;
    logic          irq;
`ifdef MMIO_TIMER_PWM_EN
    logic          pwm_out;
`endif

    always #5 clk = ~clk;

    mmio_timer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .address    (address),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
`ifdef MMIO_TIMER_PWM_EN
        .pwm_out    (pwm_out),
`endif
        .irq        (irq)
    );

    int checks = 0;
    int failures = 0;

    // Scoreboard: expected read data and the cycle its ready pulse is due.
    logic [DW-1:0] exp_q[$];
    int            due_q[$];

    // Reference model state.
    logic [3:0]      m_ctrl;
    logic [CW-1:0]   m_prescale, m_count, m_compare;
    logic            m_match, m_irq, m_pwm;
    longint unsigned m_elapsed;   // enabled cycles since the prescale period was restarted
    int              cyc = 0;
    bit              m_live = 1'b0;

    function automatic logic [DW-1:0] model_read(input int idx);
        case (idx)
            0:       return {60'd0, m_ctrl};
            1:       return {32'd0, m_prescale};
            2:       return {32'd0, m_count};
            3:       return {32'd0, m_compare};
            4:       return {63'd0, m_match};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin : model_p
        bit            acc, wr, tick, set_now, cnt_wr, irq_n, pwm_n;
        int            idx;
        logic [CW-1:0] wd, n_count;
        logic          n_match;
        cyc++;
        if (reset) begin
            m_ctrl = '0; m_prescale = '0; m_count = '0; m_compare = '1;
            m_match = 1'b0; m_irq = 1'b0; m_pwm = 1'b0; m_elapsed = 0;
            m_live = 1'b1;
        end else begin
            acc = sel && (read_en || write_en);
            wr  = sel && write_en;
            idx = int'(address[5:3]);
            wd  = write_data[CW-1:0];
            if (acc) begin
                exp_q.push_back(read_en ? model_read(idx) : '0);
                due_q.push_back(cyc);
            end
            tick    = m_ctrl[0] && ((m_elapsed % (64'(m_prescale) + 64'd1)) == 64'(m_prescale));
            irq_n   = m_match && m_ctrl[2];
            pwm_n   = (m_ctrl[0] && (m_count < m_compare)) ^ m_ctrl[3];
            cnt_wr  = wr && idx == 2;
            set_now = tick && !cnt_wr && (m_count == m_compare);
            n_count = m_count;
            if (cnt_wr) n_count = wd;
            else if (tick) n_count = (set_now && m_ctrl[1]) ? '0 : m_count + 1;
            n_match = m_match;
            if (wr && idx == 4 && wd[0]) n_match = 1'b0;
            if (set_now) n_match = 1'b1;
            m_elapsed = m_ctrl[0] ? m_elapsed + 1 : 0;
            if (wr && (idx == 0 || idx == 1)) m_elapsed = 0;
            if (wr && idx == 0) m_ctrl = wd[3:0] & CTRL_MASK;
            if (wr && idx == 1) m_prescale = wd;
            if (wr && idx == 3) m_compare = wd;
            m_count = n_count;
            m_match = n_match;
            m_irq   = irq_n;
            m_pwm   = pwm_n;
        end
    end

    always @(negedge clk) begin : monitor_p
        if (m_live) begin
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL irq cyc=%0d got=%b exp=%b", cyc, irq, m_irq);
            end
`ifdef MMIO_TIMER_PWM_EN
            checks++;
            if (pwm_out !== m_pwm) begin
                failures++;
                $display("FAIL pwm_out cyc=%0d got=%b exp=%b", cyc, pwm_out, m_pwm);
            end
`endif
            if (ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ready_unexpected cyc=%0d got=1 exp=0", cyc);
                end else begin
                    logic [DW-1:0] e;
                    int            d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (d != cyc) begin
                        failures++;
                        $display("FAIL ready_latency cyc=%0d got=%0d exp=%0d", cyc, cyc, d);
                    end
                    checks++;
                    if (read_data !== e) begin
                        failures++;
                        $display("FAIL read_data cyc=%0d got=%h exp=%h", cyc, read_data, e);
                    end
                end
            end else begin
                checks++;
                if (ready !== 1'b0 || read_data !== '0) begin
                    failures++;
                    $display("FAIL idle_outputs cyc=%0d got ready=%b data=%h exp ready=0 data=0",
                             cyc, ready, read_data);
                end
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                    checks++;
                    failures++;
                    $display("FAIL ready_missing cyc=%0d got=0 exp=1", cyc);
                end
            end
        end
    end

    task automatic drive(input bit s, input bit rd, input bit wr, input int idx, input logic [31:0] d);
        @(negedge clk);
        sel        = s;
        read_en    = rd;
        write_en   = wr;
        address    = {3'(idx), 3'($urandom_range(0, 7))};
        write_data = {32'($urandom), d};
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, idx, d);
    endtask

    task automatic rd_reg(input int idx);
        drive(1'b1, 1'b1, 1'b0, idx, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 32'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 5; i++) rd_reg(i);
        idle(2);
    endtask

    function automatic logic [31:0] pick_data(input int idx);
        case (idx)
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'($urandom_range(0, 3));
            2:       return 32'($urandom_range(0, 12));
            3:       return 32'($urandom_range(0, 12));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values, back-to-back reads.
        read_all();

        // Prescaled count with autoreload and interrupt.
        wr_reg(1, 32'd3);
        wr_reg(3, 32'd5);
        wr_reg(0, 32'h7);
        for (int i = 0; i < 28; i++) rd_reg(2);
        rd_reg(4);
        idle(3);

        // Wrap through zero without autoreload.
        wr_reg(0, 32'h0);
        wr_reg(1, 32'd0);
        wr_reg(2, 32'hFFFF_FFFE);
        wr_reg(3, 32'h10);
        wr_reg(4, 32'h1);
        wr_reg(0, 32'h1);
        for (int i = 0; i < 22; i++) rd_reg((i % 4 == 3) ? 4 : 2);
        idle(2);

        // COUNT write coincident with tick; W1C coincident with match (read+write together).
        wr_reg(2, 32'h100);
        rd_reg(2);
        wr_reg(3, 32'h103);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 4, 32'h1);
        idle(2);

        // Back-to-back STATUS traffic and a deselected write.
        wr_reg(0, 32'h5);
        wr_reg(2, 32'd0);
        wr_reg(3, 32'd2);
        idle(5);
        wr_reg(0, 32'h0);
        rd_reg(4);
        wr_reg(4, 32'h1);
        rd_reg(4);
        drive(1'b0, 1'b0, 1'b1, 2, 32'h55);
        rd_reg(2);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            int idx;
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 2) idle(1);
            else drive($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom), idx, pick_data(idx));
        end
        idle(2);

        // Reset during a pending read.
        wr_reg(0, 32'h1);
        wr_reg(2, 32'h20);
        @(negedge clk);
        reset = 1'b1; sel = 1'b1; read_en = 1'b1; write_en = 1'b0; address = 6'h10;
        @(negedge clk);
        reset = 1'b0; sel = 1'b0; read_en = 1'b0;
        read_all();

        // PWM waveform, plain and inverted; CTRL bit3 readback.
        wr_reg(3, 32'd4);
        wr_reg(0, 32'h3);
        idle(15);
        wr_reg(0, 32'hB);
        rd_reg(0);
        idle(12);
        rd_reg(0);
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
